// File: rtl/scroll_sequencer.sv
// scroll_sequencer: frame-synchronous X/Y scroll offset controller with run/pause/step modes.
// Latency: vsync rise sampled at edge N -> frame_tick in cycle N+1 -> new offsets/state from cycle N+2.
// Backpressure: one-deep command slot; cmd_ready stays low from acceptance until the committing tick.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   vsync_in              vertical sync (high = pulse), same clock domain
//   cmd_valid/cmd_ready   command handshake; cmd_op 0=SET_SPEED_X 1=SET_SPEED_Y 2=SET_MODE 3=STEP
//   cmd_data              operand (speeds use [3:0]; SET_MODE uses [0]=run, [1]=zero offsets)
//   frame_tick            one-cycle pulse per frame
//   x_offset, y_offset    scroll offsets added to pixel coordinates downstream
//   frame_count           frames since reset (wraps)
//   running               high while in RUNNING
//
// Build option: define SCROLL_BOUNCE_EN to make offsets bounce between 0 and X_MAX/Y_MAX
// (speed sign flips at each wall); otherwise offsets wrap modulo 1024.
module scroll_sequencer #(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        frame_tick,
  output logic [9:0]  x_offset,
  output logic [9:0]  y_offset,
  output logic [15:0] frame_count,
  output logic        running
);

`ifdef SCROLL_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  localparam logic [1:0] ST_RUNNING    = 2'd0;
  localparam logic [1:0] ST_PAUSED     = 2'd1;
  localparam logic [1:0] ST_STEP_ARMED = 2'd2;

  localparam logic [1:0] OP_SET_SPEED_X = 2'd0;
  localparam logic [1:0] OP_SET_SPEED_Y = 2'd1;
  localparam logic [1:0] OP_SET_MODE    = 2'd2;
  localparam logic [1:0] OP_STEP        = 2'd3;

  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);

  logic        vsync_q, vsync_d;
  logic        tick_q, tick_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_op_q, pend_op_d;
  logic [3:0]  pend_data_q, pend_data_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  speed_x_q, speed_x_d;
  logic [3:0]  speed_y_q, speed_y_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] fc_q, fc_d;

  // Only the low nibble of the operand carries meaning for any opcode.
  logic unused_cmd_hi;
  assign unused_cmd_hi = ^cmd_data[7:4];

  // Negation with -8 saturating to +7 so the magnitude never grows.
  function automatic logic [3:0] neg_sat(input logic [3:0] s);
    return (s == 4'b1000) ? 4'b0111 : 4'(~s + 4'd1);
  endfunction

  // One axis advance: returns {new_speed, new_offset}.
  // A negative speed can only underflow; a positive one can only overshoot the limit.
  function automatic logic [13:0] step_axis(input logic [9:0] off, input logic [3:0] spd,
                                            input logic [10:0] lim);
    logic [10:0] nxt;
    nxt = {1'b0, off} + {{7{spd[3]}}, spd};
    if (BOUNCE_EN && spd[3] && nxt[10])
      return {neg_sat(spd), 10'd0};
    if (BOUNCE_EN && !spd[3] && (nxt > lim))
      return {neg_sat(spd), lim[9:0]};
    return {spd, nxt[9:0]};
  endfunction

  logic [3:0] eff_sx, eff_sy;
  logic       zero_offs, advance;

  always_comb begin
    vsync_d     = vsync_in;
    tick_d      = vsync_in & ~vsync_q;
    pend_d      = pend_q;
    pend_op_d   = pend_op_q;
    pend_data_d = pend_data_q;
    state_d     = state_q;
    speed_x_d   = speed_x_q;
    speed_y_d   = speed_y_q;
    x_d         = x_q;
    y_d         = y_q;
    fc_d        = fc_q;
    eff_sx      = speed_x_q;
    eff_sy      = speed_y_q;
    zero_offs   = 1'b0;
    advance     = 1'b0;

    if (tick_q) begin
      fc_d   = fc_q + 16'd1;
      pend_d = 1'b0;
      // An armed step always falls back to PAUSED unless a SET_MODE says otherwise.
      if (state_q == ST_STEP_ARMED) state_d = ST_PAUSED;
      if (pend_q) begin
        case (pend_op_q)
          OP_SET_SPEED_X: eff_sx = pend_data_q;
          OP_SET_SPEED_Y: eff_sy = pend_data_q;
          OP_SET_MODE: begin
            state_d   = pend_data_q[0] ? ST_RUNNING : ST_PAUSED;
            zero_offs = pend_data_q[1];
          end
          OP_STEP: if (state_q == ST_PAUSED) state_d = ST_STEP_ARMED;
          default: ;
        endcase
      end
      // The step's single advance belongs to the tick that leaves STEP_ARMED.
      advance   = ~zero_offs & ((state_q == ST_STEP_ARMED) | (state_d == ST_RUNNING));
      speed_x_d = eff_sx;
      speed_y_d = eff_sy;
      if (zero_offs) begin
        x_d = 10'd0;
        y_d = 10'd0;
      end else if (advance) begin
        {speed_x_d, x_d} = step_axis(x_q, eff_sx, X_LIM);
        {speed_y_d, y_d} = step_axis(y_q, eff_sy, Y_LIM);
      end
    end

    // Slot is empty here only if it was empty entering the cycle, so a tick-cycle
    // acceptance waits for the following frame.
    if (cmd_valid && !pend_q) begin
      pend_d      = 1'b1;
      pend_op_d   = cmd_op;
      pend_data_d = cmd_data[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      tick_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_op_q   <= 2'd0;
      pend_data_q <= 4'd0;
      state_q     <= ST_RUNNING;
      speed_x_q   <= 4'd1;
      speed_y_q   <= 4'd0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      fc_q        <= 16'd0;
    end else begin
      vsync_q     <= vsync_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_op_q   <= pend_op_d;
      pend_data_q <= pend_data_d;
      state_q     <= state_d;
      speed_x_q   <= speed_x_d;
      speed_y_q   <= speed_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fc_q        <= fc_d;
    end
  end

  assign cmd_ready   = ~pend_q;
  assign frame_tick  = tick_q;
  assign x_offset    = x_q;
  assign y_offset    = y_q;
  assign frame_count = fc_q;
  assign running     = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed bench for scroll_sequencer with an expected-frame queue.
// Each frame's expected offsets/count/run flag are queued before vsync is driven and
// popped once the tick has been processed.
module tb_scroll_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_in = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic        cmd_ready, frame_tick, running;
  logic [9:0]  x_offset, y_offset;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
    logic        run;
  } exp_t;
  exp_t sb[$];

  logic rdy_in_tick, rdy_after_tick;

  scroll_sequencer dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .frame_tick(frame_tick), .x_offset(x_offset), .y_offset(y_offset),
    .frame_count(frame_count), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input int x, input int y, input int fc, input logic run);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.fc = 16'(fc); e.run = run;
    sb.push_back(e);
  endtask

  // One frame: raise vsync, see a single tick, compare the queued expectation,
  // hold vsync high for 'hold' cycles and confirm no further tick.
  task automatic frame(input int hold, input logic inj, input logic [1:0] op, input logic [7:0] d);
    int   n;
    int   extra;
    exp_t e;
    @(posedge clk); #1 vsync_in = 1'b1;
    n = 0;
    while (frame_tick !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("tick_rise", frame_tick, 1);
    rdy_in_tick = cmd_ready;
    if (inj) begin
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    end
    @(posedge clk); #1;
    if (inj) cmd_valid = 1'b0;
    check("tick_single", frame_tick, 0);
    rdy_after_tick = cmd_ready;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("x_offset", x_offset, e.x);
      check("y_offset", y_offset, e.y);
      check("frame_count", frame_count, e.fc);
      check("running", running, e.run);
    end
    extra = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (frame_tick) extra++;
    end
    vsync_in = 1'b0;
    check("tick_held_once", extra, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_offer_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_ready_low", cmd_ready, 0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", x_offset, 0);
    check("rst_y", y_offset, 0);
    check("rst_fc", frame_count, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_running", running, 1);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // Free-running at default speed +1
    expect_frame(1, 0, 1, 1); frame(2, 0, 0, 0);
    expect_frame(2, 0, 2, 1); frame(2, 0, 0, 0);
    expect_frame(3, 0, 3, 1); frame(8, 0, 0, 0);

`ifdef SCROLL_BOUNCE_EN
    // Walk up to 636 at +3, then +7 bounces off X_MAX=639 and reverses
    send_cmd(2'd0, 8'h03);
    for (int k = 1; k <= 211; k++) begin
      expect_frame(3 + 3 * k, 0, 3 + k, 1);
      frame(1, 0, 0, 0);
    end
    send_cmd(2'd0, 8'h07);
    expect_frame(639, 0, 215, 1); frame(1, 0, 0, 0);
    expect_frame(632, 0, 216, 1); frame(1, 0, 0, 0);
`else
    // SET_SPEED_X -3 applies on its commit tick, then wraps below zero
    send_cmd(2'd0, 8'h0D);
    expect_frame(0, 0, 4, 1); frame(2, 0, 0, 0);
    check("ready_low_in_tick", rdy_in_tick, 0);
    check("ready_after_commit", rdy_after_tick, 1);
    expect_frame(1021, 0, 5, 1); frame(2, 0, 0, 0);

    // Pause, then single step
    send_cmd(2'd2, 8'h00);
    expect_frame(1021, 0, 6, 0); frame(2, 0, 0, 0);
    expect_frame(1021, 0, 7, 0); frame(2, 0, 0, 0);
    send_cmd(2'd3, 8'h00);
    expect_frame(1021, 0, 8, 0); frame(2, 0, 0, 0);
    expect_frame(1018, 0, 9, 0); frame(2, 0, 0, 0);
    expect_frame(1018, 0, 10, 0); frame(2, 0, 0, 0);

    // Upper operand nibble ignored: 0xF2 sets speed_y to +2
    send_cmd(2'd1, 8'hF2);
    expect_frame(1018, 0, 11, 0); frame(2, 0, 0, 0);

    // Run + zero offsets: no advance on commit tick, advancing afterwards
    send_cmd(2'd2, 8'h03);
    expect_frame(0, 0, 12, 1); frame(2, 0, 0, 0);
    expect_frame(1021, 2, 13, 1); frame(2, 0, 0, 0);

    // Command offered in the tick cycle: accepted there, committed a frame later
    expect_frame(1018, 4, 14, 1); frame(2, 1, 2'd0, 8'h02);
    check("tick_cycle_ready", rdy_in_tick, 1);
    check("tick_cmd_pending", cmd_ready, 0);

    // Second command held off while the slot is full
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("holdoff_ready", cmd_ready, 0);
    end
    expect_frame(1020, 6, 15, 1); frame(2, 0, 0, 0);
    check("holdoff_ready_in_tick", rdy_in_tick, 0);
    check("holdoff_ready_after", rdy_after_tick, 1);
    cmd_valid = 1'b0;
    check("second_cmd_taken", cmd_ready, 0);
    expect_frame(1022, 7, 16, 1); frame(2, 0, 0, 0);
    expect_frame(0, 8, 17, 1); frame(2, 0, 0, 0);

    // STEP while running is a no-op
    send_cmd(2'd3, 8'h00);
    expect_frame(2, 9, 18, 1); frame(2, 0, 0, 0);
`endif

    // Mid-frame asynchronous reset drops a pending command
    send_cmd(2'd0, 8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", x_offset, 0);
    check("arst_y", y_offset, 0);
    check("arst_fc", frame_count, 0);
    check("arst_tick", frame_tick, 0);
    check("arst_running", running, 1);
    check("arst_ready", cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_frame(1, 0, 1, 1); frame(2, 0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scroll_sequencer.md
# scroll_sequencer

Frame-synchronous scroll controller for the VGA pattern datapath. It detects each frame start from `vsync` in the pixel-clock domain and advances signed X/Y scroll offsets once per frame. It also sequences run, pause and single-step modes. It replaces a free-running vsync-clocked counter with a fully synchronous block that upstream logic (input pins or a future register interface) configures through a valid/ready command port. Offsets feed the pattern generator as `pix_x + x_offset` and `pix_y + y_offset`.

## Interface
Parameters:
- `X_MAX`, default 639: upper X offset limit in bounce mode.
- `Y_MAX`, default 479: upper Y offset limit in bounce mode.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vsync_in`  in  1  vertical sync from the hvsync generator, same clock domain; high = sync pulse.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  pending slot empty.
- `cmd_op`  in  2  opcode: 0 SET_SPEED_X, 1 SET_SPEED_Y, 2 SET_MODE, 3 STEP.
- `cmd_data`  in  8  operand.
- `frame_tick`  out  1  one-cycle pulse per frame.
- `x_offset`  out  10  horizontal scroll offset.
- `y_offset`  out  10  vertical scroll offset.
- `frame_count`  out  16  frames since reset.
- `running`  out  1  high in RUNNING state.

## Operation
- **Edge detect:** `vsync_q` is a registered copy of `vsync_in`. `frame_tick = vsync_in & ~vsync_q`, registered.
- **Active settings:** `speed_x` and `speed_y` are 4-bit signed values (−8..+7). Reset values: `speed_x = +1`, `speed_y = 0`.
- **Command slot:** one entry deep. `cmd_ready = ~pending`. A command is accepted when `cmd_valid & cmd_ready` at a clock edge; `cmd_op`/`cmd_data` are captured and `pending` is set.
- **Order of events at each `frame_tick`:**
  1. Commit the pending command and clear `pending`.
  2. Update the FSM.
  3. Advance offsets if the state permits.
- **Commit semantics:**
  - SET_SPEED_X / SET_SPEED_Y: load `cmd_data[3:0]`; `cmd_data[7:4]` are ignored.
  - SET_MODE: `cmd_data[0]` = 1 selects RUNNING, 0 selects PAUSED. If `cmd_data[1]` = 1, both offsets are zeroed and no advance happens that frame.
  - STEP: valid only in PAUSED.
- **FSM states:** RUNNING (reset state), PAUSED, STEP_ARMED.
  - RUNNING: advance every tick. SET_MODE run=0 moves to PAUSED.
  - PAUSED: no advance. STEP moves to STEP_ARMED with no advance on the commit tick. SET_MODE run=1 moves to RUNNING.
  - STEP_ARMED: at the next tick, advance once and return to PAUSED. A SET_MODE committed on that same tick overrides the return state; the single advance still occurs.
  - STEP committed in RUNNING or STEP_ARMED is a no-op.
- **Advance:** `offset_next = offset + sign_extend(speed)`, computed at 11 bits.
- **`frame_count`:** increments on every tick in all states and wraps from 0xFFFF to 0.
- **`running`:** equals (state == RUNNING).

## Timing
- Reset values: `x_offset` = 0, `y_offset` = 0, `frame_count` = 0, `frame_tick` = 0, `running` = 1, `cmd_ready` = 1. The pending slot is cleared.
- If `vsync_in` rises in cycle N (sampled at edge N), `frame_tick` is high in cycle N+1 only.
- Offsets, `frame_count`, FSM state and `running` change at the edge ending the tick cycle, so the new values are visible from cycle N+2.
- A command accepted at the edge ending the tick cycle is not committed until the following frame.
- `cmd_ready` returns high one cycle after the committing tick.
- `vsync_in` held high produces exactly one tick. A glitch-free low→high transition is required for each frame.
- Asserting `rst_n` low mid-frame or mid-handshake clears all state immediately; an accepted but uncommitted command is lost.

## Configuration
- Macro: `SCROLL_BOUNCE_EN`.
- Defined:
  - If X `offset_next` > `X_MAX`, `x_offset` = `X_MAX` and `speed_x` = −`speed_x`.
  - If X `offset_next` < 0, `x_offset` = 0 and `speed_x` = −`speed_x`.
  - Y behaves the same against `Y_MAX`.
  - Negating −8 yields +7 (saturating).
- Undefined: offsets wrap modulo 1024; `X_MAX`/`Y_MAX` are unused and speeds never change sign by themselves.

## Test plan
- Reset, then 3 vsync pulses → 3 single-cycle ticks; `x_offset` = 3, `y_offset` = 0, `frame_count` = 3, `running` = 1.
- SET_SPEED_X data 0x0D (−3) accepted mid-frame → `cmd_ready` low until the next tick. Advance uses −3 on that same tick: 3 → 0, next frame 0 → 1021 (wrap build).
- SET_MODE 0x00, then STEP over the following frames:
  - 0x00 → PAUSED, offsets frozen, `frame_count` still counting.
  - STEP → STEP_ARMED, no advance on the commit tick.
  - Next tick → exactly one advance, back to PAUSED.
- SET_MODE 0x03 with `x_offset` = 200 → offsets 0 on the commit tick, RUNNING, advancing from the next tick.
- Command offered in the tick cycle with slot empty → accepted, committed one frame later. Second command while pending → `cmd_ready` 0, held off.
- `SCROLL_BOUNCE_EN` defined, `speed_x` = +7, `x_offset` = 636 → tick gives 639 and `speed_x` = −7; next tick gives 632. Also assert `rst_n` mid-frame → all outputs return to reset values immediately.
